// File: rtl/drum_pkg.sv
// drum_pkg: shared constants, S1 payload type and the index-to-shift helper
// used by the DRUM approximate multiplier back end.
package drum_pkg;

  localparam int DRUM_IDX_W   = 4;   // leading-one index width
  localparam int DRUM_OUT_W   = 32;  // full-scale result width (2*16)
  localparam int DRUM_SHIFT_W = 5;   // combined shift amount width

  // Payload carried from S1 to S2. The product is already zero-extended to
  // full width so S2 only has to shift.
  typedef struct packed {
    logic [DRUM_OUT_W-1:0]   prod;
    logic [DRUM_SHIFT_W-1:0] shift;
    logic                    zero;
  } drum_s1_t;

  // Shift contributed by one operand: how far its leading one sat above the
  // kept K-bit window. An index below K-1 with trunc set wraps modulo 32.
  function automatic logic [DRUM_SHIFT_W-1:0] drum_shift(
    input logic [DRUM_IDX_W-1:0] idx,
    input logic                  trunc,
    input int                    k
  );
    logic [DRUM_SHIFT_W-1:0] amt;
    amt = {1'b0, idx} - DRUM_SHIFT_W'(k - 1);
    return trunc ? amt : '0;
  endfunction

endpackage

// File: rtl/drum_result_decoder_if.sv
// drum_result_decoder_if: valid/ready input channel (product + indices) and
// valid/ready output channel (restored result).
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the decoder (drives in_ready, out_valid, out_result)
interface drum_result_decoder_if
  import drum_pkg::*;
#(
  parameter int K     = 6,
  parameter int OUT_W = DRUM_OUT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [2*K-1:0]        in_prod;
  logic [DRUM_IDX_W-1:0] in_lza;
  logic [DRUM_IDX_W-1:0] in_lzb;
  logic                  in_trunc_a;
  logic                  in_trunc_b;
  logic                  in_zero;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_result;

  modport master (
    output in_valid, in_prod, in_lza, in_lzb, in_trunc_a, in_trunc_b, in_zero,
    output out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_prod, in_lza, in_lzb, in_trunc_a, in_trunc_b, in_zero,
    input  out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/drum_onehot_decoder.sv
// drum_onehot_decoder: N-bit binary index to 2^N one-hot vector; the inverse
// of the leading-one encoder.
//   idx    : binary index
//   onehot : bit idx set, all others clear
module drum_onehot_decoder #(
  parameter int N = 5
) (
  input  logic [N-1:0]      idx,
  output logic [2**N-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/drum_result_decoder.sv
// drum_result_decoder: DRUM multiplier back end. Turns the truncated KxK
// mantissa product and the two leading-one indices back into a full-scale
// 32-bit result through a two-stage valid/ready pipeline.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of drum_result_decoder_if (in_* channel, out_* channel)
module drum_result_decoder
  import drum_pkg::*;
#(
  parameter int K     = 6,
  parameter int OUT_W = DRUM_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  drum_result_decoder_if.slave  bus
);

  localparam int NSHIFT = 2**DRUM_SHIFT_W;

  drum_s1_t          s1_d;
  drum_s1_t          s1_q;
  logic              s1_valid;
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_result;
  logic              s2_adv;
  logic              accept;
  logic [NSHIFT-1:0] shift_oh;
  logic [OUT_W-1:0]  shifted;
  logic [OUT_W-1:0]  result;

  // S2 can take a new value when it is empty or its value leaves this cycle.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_d       = '0;
    s1_d.prod  = DRUM_OUT_W'(bus.in_prod);
    s1_d.shift = drum_shift(bus.in_lza, bus.in_trunc_a, K)
               + drum_shift(bus.in_lzb, bus.in_trunc_b, K);
    s1_d.zero  = bus.in_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  drum_onehot_decoder #(.N(DRUM_SHIFT_W)) u_shift_dec (
    .idx    (s1_q.shift),
    .onehot (shift_oh)
  );

  // Barrel shift as an AND-OR over the one-hot select: exactly one term
  // survives the mask.
  always_comb begin
    shifted = '0;
    for (int i = 0; i < NSHIFT; i++) begin
      shifted |= {OUT_W{shift_oh[i]}} & (OUT_W'(s1_q.prod) << i);
    end
    result = s1_q.zero ? '0 : shifted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= result;
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;

endmodule
